// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared pipeline definitions for the instruction-fetch stage.
//   - fetch FSM state encodings (IDLE/REQ/FULL/DROP)
//   - NOP_INSTR: bubble word, identical to the IF/ID flush value
//   - DEF_PC_STEP: default byte increment between sequential fetches
package fetch_unit_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;  // post-reset, no request yet
  localparam logic [1:0] ST_REQ  = 2'd1;  // request outstanding, buffer empty
  localparam logic [1:0] ST_FULL = 2'd2;  // buffer holds a valid word
  localparam logic [1:0] ST_DROP = 2'd3;  // stale request outstanding, data discarded

  localparam logic [31:0] NOP_INSTR   = 32'h0000_0000;
  localparam logic [31:0] DEF_PC_STEP = 32'd4;

endpackage

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage driving the producer side of IF/ID.
// Owns the PC, fetches over a req/ack handshake (any number of wait states),
// holds the returned word in a one-entry buffer and handles branch redirects.
//
// Ports:
//   clk_i, rst_i           clock, async active-high reset
//   stall_i                global stall: freezes PC/buffer/state (ack capture excepted)
//   hazardDetected_i       ID does not consume the buffered word this cycle
//   branchTaken_i          redirect request; branchTarget_i is the new PC
//   imem_req_o/addr_o      fetch request and address (addr = PC in all states)
//   imem_ack_i/data_i      memory response, same-cycle ack allowed
//   instr_o/instrAddr_o    buffered word and its address, 0/0 when empty
//   IFFlush_o              one-cycle pulse on an accepted redirect
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = DEF_PC_STEP
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        hazardDetected_i,
  input  logic        branchTaken_i,
  input  logic [31:0] branchTarget_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_data_i,
  output logic [31:0] instr_o,
  output logic [31:0] instrAddr_o,
  output logic        IFFlush_o
);

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] bufAddr_q, bufAddr_d;

  logic br, adv;

  // A redirect is only accepted when the pipeline moves; adv means IF/ID
  // takes the buffered word at this edge.
  assign br  = branchTaken_i & ~stall_i;
  assign adv = ~stall_i & ~hazardDetected_i & ~br;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    buf_d     = buf_q;
    bufAddr_d = bufAddr_q;
    case (state_q)
      ST_IDLE: begin
        if (br) begin
          pc_d    = branchTarget_i;
          state_d = ST_REQ;
        end else if (!stall_i) begin
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (br) begin
          pc_d = branchTarget_i;
          // Without an ack the old request is still in flight on the bus;
          // its data must be swallowed before the target is requested.
          if (!imem_ack_i) state_d = ST_DROP;
        end else if (imem_ack_i) begin
          // Captured even under stall so the memory transaction is not lost.
          buf_d     = imem_data_i;
          bufAddr_d = pc_q;
          pc_d      = pc_q + PC_STEP;
          state_d   = ST_FULL;
        end
      end
      ST_FULL: begin
        if (br) begin
          pc_d    = branchTarget_i;
          state_d = ST_REQ;
        end else if (adv) begin
          if (imem_ack_i) begin
            buf_d     = imem_data_i;
            bufAddr_d = pc_q;
            pc_d      = pc_q + PC_STEP;
          end else begin
            state_d = ST_REQ;  // request stays up, no gap
          end
        end
      end
      ST_DROP: begin
        if (br)              pc_d    = branchTarget_i;
        else if (imem_ack_i) state_d = ST_REQ;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      pc_q      <= RESET_PC;
      buf_q     <= NOP_INSTR;
      bufAddr_q <= 32'h0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      buf_q     <= buf_d;
      bufAddr_q <= bufAddr_d;
    end
  end

  // In FULL a new request only goes out when the current word is consumed,
  // which is what allows back-to-back fetches at one word per cycle.
  assign imem_req_o  = (state_q == ST_REQ) | (state_q == ST_DROP) |
                       ((state_q == ST_FULL) & adv);
  assign imem_addr_o = pc_q;
  assign instr_o     = (state_q == ST_FULL) ? buf_q : NOP_INSTR;
  assign instrAddr_o = (state_q == ST_FULL) ? bufAddr_q : 32'h0;
  assign IFFlush_o   = br;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst, stall, haz, br, req, ack, flush;
  logic [31:0] tgt, addr, data, instr, iaddr;

  // memory model controls
  bit man = 1'b0, man_ack = 1'b0, force_ack = 1'b0;
  int ws = 0;
  int wcnt = 0;

  int n_chk = 0, n_pass = 0;
  logic [63:0] q[$];  // {word, addr} expected to be consumed by IF/ID

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk_i(clk), .rst_i(rst), .stall_i(stall), .hazardDetected_i(haz),
    .branchTaken_i(br), .branchTarget_i(tgt),
    .imem_req_o(req), .imem_addr_o(addr), .imem_ack_i(ack), .imem_data_i(data),
    .instr_o(instr), .instrAddr_o(iaddr), .IFFlush_o(flush)
  );

  function automatic logic [31:0] dat(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  assign ack  = force_ack | (req & (man ? man_ack : (wcnt == ws)));
  assign data = force_ack ? 32'hDEAD_BEEF : dat(addr);

  always @(posedge clk) wcnt <= (req && !ack) ? wcnt + 1 : 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] a);
    q.push_back({dat(a), a});
  endtask

  task automatic do_reset();
    chk("drain", q.size(), 0);
    q.delete();
    rst = 1'b1; stall = 1'b0; haz = 1'b0; br = 1'b0; tgt = '0;
    man_ack = 1'b0; force_ack = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  // Monitor: a word is consumed whenever the buffer is shown and IF/ID advances.
  initial begin
    logic        p_rst = 1'b1, p_req = 1'b0, p_ack = 1'b0, p_br = 1'b0;
    logic [31:0] p_addr = '0;
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("flush", {31'b0, flush}, {31'b0, br & ~stall});
        if (instr != 32'h0 && !stall && !haz && !br) begin
          if (q.size() == 0) begin
            n_chk++;
            $display("FAIL extra_word: got %h @ %h, expected none", instr, iaddr);
          end else begin
            e = q.pop_front();
            chk("instr", instr, e[63:32]);
            chk("instrAddr", iaddr, e[31:0]);
          end
        end
        if (!p_rst && p_req && !p_ack && !p_br && req) chk("addr_stable", addr, p_addr);
      end
      p_rst = rst; p_req = req; p_ack = ack; p_br = br & ~stall; p_addr = addr;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; stall = 1'b0; haz = 1'b0; br = 1'b0; tgt = '0;

    // A: zero-wait stream, reset values, hazard hold at 0x10
    ws = 0; man = 1'b0;
    do_reset();
    chk("rst_req", {31'b0, req}, 0);
    chk("rst_instr", instr, 0);
    chk("rst_iaddr", iaddr, 0);
    chk("rst_addr", addr, 32'h0);
    chk("rst_flush", {31'b0, flush}, 0);
    for (int a = 0; a <= 32'h14; a += 4) push(a);
    tick();                                  // REQ + ack
    chk("A_req", {31'b0, req}, 1);
    chk("A_ack", {31'b0, ack}, 1);
    chk("A_empty", instr, 0);
    tick();
    chk("A_first", instr, dat(32'h0));
    repeat (4) tick();                       // buffer at 0x10
    haz = 1'b1; #1;
    chk("A_hz_instr", instr, dat(32'h10));
    chk("A_hz_req", {31'b0, req}, 0);
    chk("A_hz_pc", addr, 32'h14);
    tick();
    chk("A_hz2_instr", instr, dat(32'h10));
    chk("A_hz2_req", {31'b0, req}, 0);
    chk("A_hz2_pc", addr, 32'h14);
    tick();
    haz = 1'b0; #1;
    chk("A_resume_req", {31'b0, req}, 1);
    chk("A_resume_addr", addr, 32'h14);
    tick();
    chk("A_next", instr, dat(32'h14));
    tick();
    haz = 1'b1;                              // freeze with 0x18 unconsumed

    // B: three wait states per fetch
    ws = 3;
    do_reset();
    push(32'h0);
    tick();
    chk("B_req", {31'b0, req}, 1);
    for (int i = 0; i < 3; i++) begin
      chk("B_wait_instr", instr, 0);
      chk("B_wait_ack", {31'b0, ack}, 0);
      tick();
    end
    chk("B_ack", {31'b0, ack}, 1);
    chk("B_ack_instr", instr, 0);
    tick();
    chk("B_word0", instr, dat(32'h0));
    chk("B_next_addr", addr, 32'h4);
    repeat (3) begin
      tick();
      chk("B_wait2_instr", instr, 0);
    end
    tick();
    chk("B_word4", instr, dat(32'h4));
    haz = 1'b1;

    // C: redirect while REQ is unacked at 0x20, stale ack two cycles later
    ws = 0; man = 1'b0;
    do_reset();
    for (int a = 0; a <= 32'h1C; a += 4) push(a);
    push(32'h100);
    repeat (9) tick();
    man = 1'b1; man_ack = 1'b0; #1;
    chk("C_buf1c", instr, dat(32'h1C));
    tick();
    chk("C_req20", addr, 32'h20);
    chk("C_req20_empty", instr, 0);
    br = 1'b1; tgt = 32'h100; #1;
    chk("C_flush", {31'b0, flush}, 1);
    tick();
    br = 1'b0; #1;
    chk("C_flush_end", {31'b0, flush}, 0);
    chk("C_drop_req", {31'b0, req}, 1);
    chk("C_drop_addr", addr, 32'h100);
    tick();
    man_ack = 1'b1;                          // stale ack
    tick();
    man_ack = 1'b0; #1;
    chk("C_refetch_addr", addr, 32'h100);
    chk("C_refetch_req", {31'b0, req}, 1);
    chk("C_stale_gone", instr, 0);
    tick();
    man_ack = 1'b1;
    tick();
    man_ack = 1'b0; #1;
    chk("C_target_word", instr, dat(32'h100));
    chk("C_target_addr", iaddr, 32'h100);
    tick();

    // D: branch under stall, then two more branches during DROP
    man = 1'b1;
    do_reset();
    push(32'h400);
    tick();
    stall = 1'b1; br = 1'b1; tgt = 32'h200; #1;
    chk("D_stall_flush", {31'b0, flush}, 0);
    chk("D_stall_addr", addr, 32'h0);
    tick();
    chk("D_stall_pc", addr, 32'h0);
    stall = 1'b0; #1;
    chk("D_unstall_flush", {31'b0, flush}, 1);
    tick();
    chk("D_drop_t1", addr, 32'h200);
    tgt = 32'h300;
    tick();
    chk("D_drop_t2", addr, 32'h300);
    tgt = 32'h400;
    tick();
    br = 1'b0; #1;
    chk("D_drop_t3", addr, 32'h400);
    man_ack = 1'b1;
    repeat (2) tick();
    man_ack = 1'b0; #1;
    chk("D_last_target", instr, dat(32'h400));
    chk("D_last_taddr", iaddr, 32'h400);
    tick();

    // E: reset mid-wait with a late ack, then PC wrap at 0xFFFF_FFFC
    man = 1'b1;
    do_reset();
    push(32'h0); push(32'hFFFF_FFFC); push(32'h0);
    tick();
    tick();
    rst = 1'b1; #1;
    chk("E_rst_req", {31'b0, req}, 0);
    chk("E_rst_addr", addr, 32'h0);
    tick();
    rst = 1'b0; force_ack = 1'b1;            // ack for the pre-reset request
    tick();
    force_ack = 1'b0; #1;
    chk("E_restart_req", {31'b0, req}, 1);
    chk("E_restart_addr", addr, 32'h0);
    chk("E_ack_ignored", instr, 0);
    man_ack = 1'b1;
    tick();
    man_ack = 1'b0; #1;
    chk("E_word0", instr, dat(32'h0));
    tick();
    br = 1'b1; tgt = 32'hFFFF_FFFC;
    tick();
    br = 1'b0; man_ack = 1'b1;
    repeat (2) tick();
    chk("E_wrap_pc", addr, 32'h0);
    chk("E_top_word", instr, dat(32'hFFFF_FFFC));
    tick();
    man_ack = 1'b0; #1;
    chk("E_wrap_word", instr, dat(32'h0));
    chk("E_wrap_iaddr", iaddr, 32'h0);
    tick();
    chk("drain", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
